sqrt2_arbiter: RTL

SQRT2_ARBITER -- requirements
Module: sqrt2_arbiter

---
 rtl/sqrt2_ctrl_pkg.sv | 8 +
 rtl/sqrt2_rr_arb.sv | 27 ++
 rtl/sqrt2_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sqrt2_ctrl_pkg.sv
// sqrt2_ctrl_pkg: FSM states, quiet-NaN constant and flag bit positions shared by the sqrt2 arbiter.
package sqrt2_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, RESP, GAP} state_t;
   localparam logic [15:0] QNAN_H    = 16'h7E00;
   localparam int          FLAG_NAN  = 2;
   localparam int          FLAG_PINF = 1;
   localparam int          FLAG_NINF = 0;
endpackage

// File: rtl/sqrt2_rr_arb.sv
// sqrt2_rr_arb: combinational round-robin pick; priority starts one past the last grant.
module sqrt2_rr_arb #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [2:0]       i_last_grant,
   output logic [N_REQ-1:0] o_grant,
   output logic [2:0]       o_idx
);
   logic [3:0] w_best;
   logic [3:0] w_dist;
   // w_dist is (j - last - 1) mod N_REQ: the lowest distance wins.
   always_comb begin
      w_best = 4'(N_REQ);
      w_dist = '0;
      o_idx  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         w_dist = 4'(j) + 4'(N_REQ) - 4'd1 - {1'b0, i_last_grant};
         if (w_dist >= 4'(N_REQ)) w_dist = w_dist - 4'(N_REQ);
         if (i_req[j] && w_dist < w_best) begin
            w_best = w_dist;
            o_idx  = 3'(j);
         end
      end
   end
   assign o_grant = (w_best != 4'(N_REQ)) ? N_REQ'(1) << o_idx : '0;
endmodule

// File: rtl/sqrt2_arbiter.sv
// sqrt2_arbiter: round-robin front end sharing one sqrt2 unit among N_REQ requesters.
// Define SQRT2_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with a quiet-NaN response.
module sqrt2_arbiter
   import sqrt2_ctrl_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [16*N_REQ-1:0] req_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [2:0]          resp_id,
   output logic [15:0]         resp_data,
   output logic [2:0]          resp_flags,
   output logic                resp_timeout,
   output logic                SQ_ENABLE,
   inout  wire  [15:0]         SQ_DATA,
   input  logic                SQ_RESULT,
   input  logic                SQ_IS_NAN,
   input  logic                SQ_IS_PINF,
   input  logic                SQ_IS_NINF
);
   state_t      r_state, w_next;
   logic [N_REQ-1:0] w_grant;
   logic [2:0]  w_idx, r_last_grant, r_resp_id, r_resp_flags, w_sq_flags;
   logic [15:0] w_ops [8];
   logic [15:0] r_operand, r_resp_data;
   logic        w_expire;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("sqrt2_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   for (genvar g = 0; g < 8; g++) begin : g_ops
      if (g < N_REQ) begin : g_on
         assign w_ops[g] = req_data[16*g +: 16];
      end else begin : g_off
         assign w_ops[g] = '0;
      end
   end

   sqrt2_rr_arb #(.N_REQ(N_REQ)) u_rr (
      .i_req       (req_valid),
      .i_last_grant(r_last_grant),
      .o_grant     (w_grant),
      .o_idx       (w_idx)
   );

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) r_state <= IDLE;
      else          r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = |req_valid ? LOAD : IDLE;
         LOAD:    w_next = WAIT;
         WAIT:    w_next = (SQ_RESULT || w_expire) ? RESP : WAIT;
         RESP:    w_next = resp_ready ? GAP : RESP;
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_sq_flags            = '0;
      w_sq_flags[FLAG_NAN]  = SQ_IS_NAN;
      w_sq_flags[FLAG_PINF] = SQ_IS_PINF;
      w_sq_flags[FLAG_NINF] = SQ_IS_NINF;
   end

   // A result arriving on the timeout cycle takes precedence over the abort.
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         r_last_grant <= 3'(N_REQ - 1);
         r_operand    <= '0;
         r_resp_id    <= '0;
         r_resp_data  <= '0;
         r_resp_flags <= '0;
      end else begin
         if (r_state == IDLE && |req_valid) begin
            r_last_grant <= w_idx;
            r_operand    <= w_ops[w_idx];
         end
         if (r_state == WAIT && SQ_RESULT) begin
            r_resp_id    <= r_last_grant;
            r_resp_data  <= SQ_DATA;
            r_resp_flags <= w_sq_flags;
         end else if (r_state == WAIT && w_expire) begin
            r_resp_id    <= r_last_grant;
            r_resp_data  <= QNAN_H;
            r_resp_flags <= 3'(1 << FLAG_NAN);
         end
      end

`ifdef SQRT2_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_resp_timeout;
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         r_cnt          <= '0;
         r_resp_timeout <= 1'b0;
      end else begin
         r_cnt <= (r_state == LOAD) ? '0 : (r_state == WAIT) ? r_cnt + 16'd1 : r_cnt;
         if (r_state == WAIT && (SQ_RESULT || w_expire)) r_resp_timeout <= !SQ_RESULT;
      end
   assign w_expire     = (r_state == WAIT) && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign resp_timeout = r_resp_timeout;
`else
   assign w_expire     = 1'b0;
   assign resp_timeout = 1'b0;
`endif

   assign req_ready  = (r_state == IDLE && RESET_N) ? w_grant : '0;
   assign resp_valid = (r_state == RESP);
   assign resp_id    = r_resp_id;
   assign resp_data  = r_resp_data;
   assign resp_flags = r_resp_flags;
   assign SQ_ENABLE  = r_state inside {LOAD, WAIT, RESP};
   assign SQ_DATA    = (r_state == LOAD) ? r_operand : 16'hzzzz;
endmodule
